core: RTL and testbench
=======================

CORE -- requirements
Module: core

Interface
REQ-001 Parameters: bw=4 (operand width); psum_bw=16 (accumulator width); row=8 (output pixels); col=8 (output channels).
REQ-002 clk  in  1  sole clock; all state updates on the rising edge.
REQ-003 reset  in  1  asynchronous, active-high.
REQ-004 inst  in  64  control word, fields listed in REQ-008.
REQ-005 D_xmem  in  bw*row  write data for the activation/weight SRAM.
REQ-006 ofifo_valid  out  1  high while drained results remain to be written to psum memory.
REQ-007 sfp_out  out  col*psum_bw  post-processed psum memory read data; lane c is bits [16c+15:16c] and holds output channel c.
REQ-008 inst bit fields:
- [1] execute, [3] l0_rd, [2] l0_wr, [37] l1_wr
- [17:7] A_xmem, [18] WEN_xmem, [19] CEN_xmem
- [30:20] A_pmem, [31] WEN_pmem, [32] CEN_pmem
- [34] sfu_passthrough, [36] output_stationary, [38] recall_psum, [39] pass_psum
- All other bits (load, acc, fifo strobes, REN_pmem, debug) shall be ignored.

Function
REQ-009 xmem: 2048x32 synchronous SRAM.
- CEN=0 & WEN=0 writes D_xmem to A_xmem.
- CEN=0 & WEN=1 registers mem[A_xmem] into xq (1-cycle latency).
- Map: activations at ic*9+kij; weights at 576+ic*9+kij.
REQ-010 Word packing: activation nibble [4r+3:4r] belongs to pixel row r; weight nibble [4c+3:4c] belongs to output channel c.
REQ-011 L0 (activations) and L1 (weights): 9-entry buffers of 32 bits each.
- l0_wr/l1_wr are delayed one cycle internally to align with xmem read latency; the delayed strobe writes xq at wptr, then wptr increments.
- Writes while wptr=9 shall be dropped.
REQ-012 Pop: occurs each cycle with l0_rd=1, execute=1, output_stationary=1 and rptr<9; pops L0 and L1 together.
- After the 9th pop, both buffers' rptr and wptr shall clear to 0.
REQ-013 Array: 8x8 output-stationary systolic grid.
- Activation nibble r enters PE(r,0) r cycles after its pop and moves east one PE per cycle.
- Weight nibble c enters PE(0,c) c cycles after its pop and moves south one PE per cycle.
- Each operand carries a valid bit.
REQ-014 PE(r,c) shall accumulate acc += unsigned(act) * signed(weight) when both operands are valid. Accumulation is 16-bit two's complement and wraps modulo 2^16.
REQ-015 Accumulators persist across successive input-channel passes and clear only on reset. The last MAC of a pass completes at most 15 cycles after its last pop.
REQ-016 recall_psum=1 shall copy all 64 accumulators into a drain buffer, set drain pointer dp=7 and raise ofifo_valid.
REQ-017 psum memory: 2048 x 128 bits.
- Write occurs on a cycle with CEN_pmem=0, WEN_pmem=1, pass_psum=1 and ofifo_valid=1.
- Write address = A_pmem registered from the previous cycle; data = drain row dp (8 lanes of pixel dp).
- After each write, dp decrements; after the row-0 write, ofifo_valid falls.
REQ-018 psum read: CEN_pmem=0 registers mem[A_pmem] (1-cycle latency) regardless of WEN. A read of the address being written returns the old data.
REQ-019 SFP (combinational on read data): sfu_passthrough=1 passes each lane unchanged; sfu_passthrough=0 applies ReLU per signed 16-bit lane.
REQ-020 With output_stationary=0, no pops or MACs occur; the array holds its state.

Reset
REQ-021 Reset clears: L0/L1 pointers, pipeline valid bits, all accumulators, drain buffer, dp, ofifo_valid (0), and xq/psum read registers (sfp_out=0).
REQ-022 SRAM contents are not reset.
REQ-023 Reset mid-pass discards in-flight operands and accumulations.

Structure
REQ-024 Shared package contents: bw/psum_bw/row/col defaults, inst bit-position constants, xmem weight base 576, and kij count 9.
REQ-025 A single sub-module, os_pe (operand registers, valid bits, MAC accumulator), shall be instantiated 8x8. SRAMs, buffers and drain logic shall be inline.

Verification
REQ-026 One pass with all activations=1 and all weights=1 (9 kij), then recall and write rows to addresses 7..0 -> every lane of every address reads 9.
REQ-027 Eight input-channel passes, activation=2 and weight=-3 throughout -> every lane reads 8*9*(-6) = -432 (0xFE50) with passthrough.
REQ-028 Same data as REQ-027 with sfu_passthrough=0 -> every lane reads 0.
REQ-029 Ten l0_wr/l1_wr strobes followed by 9 pops -> only the first 9 entries are used; the next pass starts again at wptr=0.
REQ-030 Reset asserted during a pass, then one clean pass of 1x1 data -> results equal 9, with no residue from the aborted pass.
REQ-031 Read of the psum address written in the same cycle -> old data returned; new data returned on the next read.

Source files
------------

// File: rtl/core_pkg.sv
// Shared parameters, control-word bit positions and helpers for the
// output-stationary MAC core.
package core_pkg;

   localparam int def_bw      = 4;
   localparam int def_psum_bw = 16;
   localparam int def_row     = 8;
   localparam int def_col     = 8;

   localparam int xmem_depth   = 2048;
   localparam int pmem_depth   = 2048;
   localparam int addr_bw      = 11;
   localparam int kij_num      = 9;
   localparam int xmem_wt_base = 576;

   localparam int inst_execute   = 1;
   localparam int inst_l0_wr     = 2;
   localparam int inst_l0_rd     = 3;
   localparam int inst_a_xmem    = 7;
   localparam int inst_wen_xmem  = 18;
   localparam int inst_cen_xmem  = 19;
   localparam int inst_a_pmem    = 20;
   localparam int inst_wen_pmem  = 31;
   localparam int inst_cen_pmem  = 32;
   localparam int inst_sfu_pass  = 34;
   localparam int inst_out_stat  = 36;
   localparam int inst_l1_wr     = 37;
   localparam int inst_recall    = 38;
   localparam int inst_pass_psum = 39;

   typedef struct packed {
      logic               execute;
      logic               l0_rd;
      logic               l0_wr;
      logic               l1_wr;
      logic [addr_bw-1:0] a_xmem;
      logic               wen_xmem;
      logic               cen_xmem;
      logic [addr_bw-1:0] a_pmem;
      logic               wen_pmem;
      logic               cen_pmem;
      logic               sfu_passthrough;
      logic               output_stationary;
      logic               recall_psum;
      logic               pass_psum;
   } ctl_t;

   // ReLU on one signed psum lane unless passthrough is requested.
   function automatic logic [def_psum_bw-1:0] sfp_lane(input logic [def_psum_bw-1:0] v,
                                                       input logic passthrough);
      return (passthrough || !v[def_psum_bw-1]) ? v : '0;
   endfunction

endpackage

// File: rtl/os_pe.sv
// One output-stationary processing element: forwards its operands east/south
// and accumulates unsigned activation times signed weight.
module os_pe
   import core_pkg::*;
#(
   parameter int bw      = def_bw,
   parameter int psum_bw = def_psum_bw
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               en,
   input  logic [bw-1:0]      act,
   input  logic               act_vld,
   input  logic [bw-1:0]      wt,
   input  logic               wt_vld,
   output logic [bw-1:0]      act_fwd,
   output logic               act_fwd_vld,
   output logic [bw-1:0]      wt_fwd,
   output logic               wt_fwd_vld,
   output logic [psum_bw-1:0] acc
);

   logic [2*bw:0] act_ext;
   logic [2*bw:0] wt_ext;
   logic [2*bw:0] prod;

   // The product fits in 2*bw+1 bits, so a truncated multiply is exact.
   assign act_ext = {{(bw+1){1'b0}}, act_fwd};
   assign wt_ext  = {{(bw+1){wt_fwd[bw-1]}}, wt_fwd};
   assign prod    = act_ext * wt_ext;

   // NOTE: state registers use non-blocking assignments so every PE samples its neighbour's pre-edge value.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         act_fwd     <= '0;
         act_fwd_vld <= 1'b0;
         wt_fwd      <= '0;
         wt_fwd_vld  <= 1'b0;
         acc         <= '0;
      end else if (en) begin
         act_fwd     <= act;
         act_fwd_vld <= act_vld;
         wt_fwd      <= wt;
         wt_fwd_vld  <= wt_vld;
         if (act_fwd_vld && wt_fwd_vld)
            acc <= acc + {{(psum_bw-2*bw-1){prod[2*bw]}}, prod};
      end
   end

endmodule

// File: rtl/core.sv
// Output-stationary 8x8 MAC core: xmem, L0/L1 buffers, skewed systolic array,
// drain buffer, psum memory and ReLU post-processing.
module core
   import core_pkg::*;
#(
   parameter int bw      = def_bw,
   parameter int psum_bw = def_psum_bw,
   parameter int row     = def_row,
   parameter int col     = def_col
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [63:0]            inst,
   input  logic [bw*row-1:0]      D_xmem,
   output logic                   ofifo_valid,
   output logic [col*psum_bw-1:0] sfp_out
);

   localparam int dp_bw = $clog2(row);

   ctl_t ctl;
   logic unused_inst;

   assign ctl.execute           = inst[inst_execute];
   assign ctl.l0_rd             = inst[inst_l0_rd];
   assign ctl.l0_wr             = inst[inst_l0_wr];
   assign ctl.l1_wr             = inst[inst_l1_wr];
   assign ctl.a_xmem            = inst[inst_a_xmem +: addr_bw];
   assign ctl.wen_xmem          = inst[inst_wen_xmem];
   assign ctl.cen_xmem          = inst[inst_cen_xmem];
   assign ctl.a_pmem            = inst[inst_a_pmem +: addr_bw];
   assign ctl.wen_pmem          = inst[inst_wen_pmem];
   assign ctl.cen_pmem          = inst[inst_cen_pmem];
   assign ctl.sfu_passthrough   = inst[inst_sfu_pass];
   assign ctl.output_stationary = inst[inst_out_stat];
   assign ctl.recall_psum       = inst[inst_recall];
   assign ctl.pass_psum         = inst[inst_pass_psum];
   assign unused_inst = ^{inst[63:40], inst[35], inst[33], inst[6:4], inst[0]};

   logic [bw*row-1:0] xmem [xmem_depth];
   logic [bw*row-1:0] xq;

   // NOTE: SRAM arrays live in reset-free processes; only their read registers are reset.
   always_ff @(posedge clk)
      if (!ctl.cen_xmem && !ctl.wen_xmem) xmem[ctl.a_xmem] <= D_xmem;

   always_ff @(posedge clk or posedge reset)
      if (reset)                          xq <= '0;
      else if (!ctl.cen_xmem && ctl.wen_xmem) xq <= xmem[ctl.a_xmem];

   logic [bw*row-1:0] l0_buf [kij_num];
   logic [bw*col-1:0] l1_buf [kij_num];
   logic [3:0]        l0_wptr, l1_wptr, rptr;
   logic              l0_wr_d, l1_wr_d, pop, pass_done;

   assign pop       = ctl.l0_rd && ctl.execute && ctl.output_stationary && (rptr < 4'(kij_num));
   assign pass_done = pop && (rptr == 4'(kij_num - 1));

   always_ff @(posedge clk) begin
      if (l0_wr_d && l0_wptr < 4'(kij_num)) l0_buf[l0_wptr] <= xq;
      if (l1_wr_d && l1_wptr < 4'(kij_num)) l1_buf[l1_wptr] <= xq[bw*col-1:0];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         l0_wr_d <= 1'b0;
         l1_wr_d <= 1'b0;
         l0_wptr <= '0;
         l1_wptr <= '0;
         rptr    <= '0;
      end else begin
         l0_wr_d <= ctl.l0_wr;
         l1_wr_d <= ctl.l1_wr;
         if (pass_done) begin
            l0_wptr <= '0;
            l1_wptr <= '0;
            rptr    <= '0;
         end else begin
            if (pop) rptr <= rptr + 4'd1;
            if (l0_wr_d && l0_wptr < 4'(kij_num)) l0_wptr <= l0_wptr + 4'd1;
            if (l1_wr_d && l1_wptr < 4'(kij_num)) l1_wptr <= l1_wptr + 4'd1;
         end
      end
   end

   logic [bw-1:0]      act_h  [row][col+1];
   logic               act_hv [row][col+1];
   logic [bw-1:0]      wt_v   [row+1][col];
   logic               wt_vv  [row+1][col];
   logic [psum_bw-1:0] acc_grid [row][col];

   // Row r / column c enter the grid r / c cycles after the pop so wavefronts meet.
   for (genvar r = 0; r < row; r++) begin : g_act_skew
      if (r == 0) begin : g_direct
         assign act_h[0][0]  = l0_buf[rptr][bw-1:0];
         assign act_hv[0][0] = pop;
      end else begin : g_delay
         logic [bw-1:0] sh  [r];
         logic          shv [r];
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               for (int k = 0; k < r; k++) begin
                  sh[k]  <= '0;
                  shv[k] <= 1'b0;
               end
            end else if (ctl.output_stationary) begin
               sh[0]  <= l0_buf[rptr][r*bw +: bw];
               shv[0] <= pop;
               for (int k = 1; k < r; k++) begin
                  sh[k]  <= sh[k-1];
                  shv[k] <= shv[k-1];
               end
            end
         end
         assign act_h[r][0]  = sh[r-1];
         assign act_hv[r][0] = shv[r-1];
      end
   end

   for (genvar c = 0; c < col; c++) begin : g_wt_skew
      if (c == 0) begin : g_direct
         assign wt_v[0][0]  = l1_buf[rptr][bw-1:0];
         assign wt_vv[0][0] = pop;
      end else begin : g_delay
         logic [bw-1:0] sh  [c];
         logic          shv [c];
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               for (int k = 0; k < c; k++) begin
                  sh[k]  <= '0;
                  shv[k] <= 1'b0;
               end
            end else if (ctl.output_stationary) begin
               sh[0]  <= l1_buf[rptr][c*bw +: bw];
               shv[0] <= pop;
               for (int k = 1; k < c; k++) begin
                  sh[k]  <= sh[k-1];
                  shv[k] <= shv[k-1];
               end
            end
         end
         assign wt_v[0][c]  = sh[c-1];
         assign wt_vv[0][c] = shv[c-1];
      end
   end

   for (genvar r = 0; r < row; r++) begin : g_row
      for (genvar c = 0; c < col; c++) begin : g_col
         os_pe #(.bw(bw), .psum_bw(psum_bw)) u_pe (
            .clk         (clk),
            .reset       (reset),
            .en          (ctl.output_stationary),
            .act         (act_h[r][c]),
            .act_vld     (act_hv[r][c]),
            .wt          (wt_v[r][c]),
            .wt_vld      (wt_vv[r][c]),
            .act_fwd     (act_h[r][c+1]),
            .act_fwd_vld (act_hv[r][c+1]),
            .wt_fwd      (wt_v[r+1][c]),
            .wt_fwd_vld  (wt_vv[r+1][c]),
            .acc         (acc_grid[r][c])
         );
      end
   end

   logic unused_edges;
   always_comb begin
      unused_edges = 1'b0;
      for (int r = 0; r < row; r++) unused_edges = unused_edges ^ (^{act_h[r][col], act_hv[r][col]});
      for (int c = 0; c < col; c++) unused_edges = unused_edges ^ (^{wt_v[row][c], wt_vv[row][c]});
   end

   logic [col*psum_bw-1:0] drain [row];
   logic [col*psum_bw-1:0] pmem  [pmem_depth];
   logic [col*psum_bw-1:0] pq;
   logic [dp_bw-1:0]       dp;
   logic [addr_bw-1:0]     a_pmem_q;
   logic                   pmem_wr;

   assign pmem_wr = !ctl.cen_pmem && ctl.wen_pmem && ctl.pass_psum && ofifo_valid;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int r = 0; r < row; r++) drain[r] <= '0;
         dp          <= '0;
         ofifo_valid <= 1'b0;
         a_pmem_q    <= '0;
      end else begin
         a_pmem_q <= ctl.a_pmem;
         if (ctl.recall_psum) begin
            for (int r = 0; r < row; r++)
               for (int c = 0; c < col; c++)
                  drain[r][c*psum_bw +: psum_bw] <= acc_grid[r][c];
            dp          <= dp_bw'(row - 1);
            ofifo_valid <= 1'b1;
         end else if (pmem_wr) begin
            dp <= dp - 1'b1;
            if (dp == '0) ofifo_valid <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk)
      if (pmem_wr) pmem[a_pmem_q] <= drain[dp];

   always_ff @(posedge clk or posedge reset)
      if (reset)              pq <= '0;
      else if (!ctl.cen_pmem) pq <= pmem[ctl.a_pmem];

   always_comb begin
      sfp_out = '0;
      for (int c = 0; c < col; c++)
         sfp_out[c*psum_bw +: psum_bw] = sfp_lane(pq[c*psum_bw +: psum_bw], ctl.sfu_passthrough);
   end

endmodule

// File: tb/tb_core.sv
// Self-checking bench for core: randomized passes compared against a
// sum-of-products reference model of the accumulators and psum memory.
module tb_core;
   import core_pkg::*;

   logic         clk = 1'b0;
   logic         reset;
   logic [63:0]  inst;
   logic [31:0]  D_xmem;
   logic         ofifo_valid;
   logic [127:0] sfp_out;

   core dut (
      .clk         (clk),
      .reset       (reset),
      .inst        (inst),
      .D_xmem      (D_xmem),
      .ofifo_valid (ofifo_valid),
      .sfp_out     (sfp_out)
   );

   always #5 clk = ~clk;

   int           n_cmp = 0;
   int           n_bad = 0;
   logic [15:0]  acc_m  [8][8];
   logic [127:0] pmem_m [2048];
   logic [31:0]  act_w  [10];
   logic [31:0]  wt_w   [10];

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
      $fatal(1, "watchdog");
   end

   function automatic logic [63:0] idle();
      logic [63:0] w = '0;
      w[inst_cen_xmem] = 1'b1;
      w[inst_cen_pmem] = 1'b1;
      w[inst_out_stat] = 1'b1;
      w[inst_sfu_pass] = 1'b1;
      return w;
   endfunction

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      repeat (2) cyc();
      reset = 1'b0;
      cyc();
      for (int r = 0; r < 8; r++)
         for (int c = 0; c < 8; c++) acc_m[r][c] = '0;
   endtask

   // Reference: each accumulator gains sum over kij of unsigned act * signed weight.
   task automatic model_pass();
      for (int r = 0; r < 8; r++)
         for (int c = 0; c < 8; c++)
            for (int k = 0; k < 9; k++) begin
               int a = int'(act_w[k][4*r +: 4]);
               int w = int'(wt_w[k][4*c +: 4]);
               if (w > 7) w = w - 16;
               acc_m[r][c] = acc_m[r][c] + 16'(a * w);
            end
   endtask

   function automatic logic [127:0] model_row(input int p);
      logic [127:0] v;
      for (int c = 0; c < 8; c++) v[16*c +: 16] = acc_m[p][c];
      return v;
   endfunction

   function automatic logic [127:0] relu_row(input logic [127:0] v);
      logic [127:0] o;
      for (int c = 0; c < 8; c++) o[16*c +: 16] = v[16*c+15] ? 16'h0000 : v[16*c +: 16];
      return o;
   endfunction

   task automatic write_xmem(input int addr, input logic [31:0] data);
      inst = idle();
      inst[inst_cen_xmem] = 1'b0;
      inst[inst_wen_xmem] = 1'b0;
      inst[inst_a_xmem +: addr_bw] = addr_bw'(addr);
      D_xmem = data;
      cyc();
      inst = idle();
   endtask

   task automatic stage(input int act_base, input int wt_base, input int n);
      for (int k = 0; k < n; k++) begin
         inst = idle();
         inst[inst_cen_xmem] = 1'b0;
         inst[inst_wen_xmem] = 1'b1;
         inst[inst_a_xmem +: addr_bw] = addr_bw'(act_base + k);
         inst[inst_l0_wr] = 1'b1;
         cyc();
      end
      inst = idle();
      cyc();
      for (int k = 0; k < n; k++) begin
         inst = idle();
         inst[inst_cen_xmem] = 1'b0;
         inst[inst_wen_xmem] = 1'b1;
         inst[inst_a_xmem +: addr_bw] = addr_bw'(wt_base + k);
         inst[inst_l1_wr] = 1'b1;
         cyc();
      end
      inst = idle();
      cyc();
   endtask

   task automatic pop(input int n, input logic os);
      for (int k = 0; k < n; k++) begin
         inst = idle();
         inst[inst_l0_rd]    = 1'b1;
         inst[inst_execute]  = 1'b1;
         inst[inst_out_stat] = os;
         cyc();
      end
      inst = idle();
   endtask

   task automatic settle();
      inst = idle();
      repeat (20) cyc();
   endtask

   task automatic run_pass(input int ic, input logic os_gap);
      for (int k = 0; k < 9; k++) begin
         write_xmem(ic*9 + k, act_w[k]);
         write_xmem(xmem_wt_base + ic*9 + k, wt_w[k]);
      end
      stage(ic*9, xmem_wt_base + ic*9, 9);
      pop(9, 1'b1);
      if (os_gap) pop(6, 1'b0);
      settle();
      model_pass();
   endtask

   task automatic drain(output logic v_rec, output logic v_mid, output logic v_end);
      inst = idle();
      inst[inst_recall] = 1'b1;
      cyc();
      v_rec = ofifo_valid;
      v_mid = 1'b0;
      inst = idle();
      inst[inst_a_pmem +: addr_bw] = addr_bw'(7);
      cyc();
      for (int i = 0; i < 8; i++) begin
         inst = idle();
         inst[inst_cen_pmem]  = 1'b0;
         inst[inst_wen_pmem]  = 1'b1;
         inst[inst_pass_psum] = 1'b1;
         inst[inst_a_pmem +: addr_bw] = addr_bw'((i < 7) ? 6 - i : 0);
         cyc();
         pmem_m[7-i] = model_row(7 - i);
         if (i == 6) v_mid = ofifo_valid;
      end
      v_end = ofifo_valid;
      inst = idle();
   endtask

   task automatic read_pmem(input int addr, input logic passthrough);
      inst = idle();
      inst[inst_cen_pmem] = 1'b0;
      inst[inst_wen_pmem] = 1'b0;
      inst[inst_sfu_pass] = passthrough;
      inst[inst_a_pmem +: addr_bw] = addr_bw'(addr);
      cyc();
   endtask

   task automatic test_reset();
      do_reset();
      n_cmp++;
      if (sfp_out !== 128'h0) begin
         n_bad++;
         $display("FAIL reset_sfp_out: got %h, want 0", sfp_out);
      end
      n_cmp++;
      if (ofifo_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_ofifo_valid: got %b, want 0", ofifo_valid);
      end
   endtask

   task automatic test_ones();
      logic v_rec, v_mid, v_end;
      do_reset();
      for (int k = 0; k < 9; k++) begin
         act_w[k] = 32'h1111_1111;
         wt_w[k]  = 32'h1111_1111;
      end
      run_pass(0, 1'b0);
      drain(v_rec, v_mid, v_end);
      n_cmp++;
      if (v_rec !== 1'b1) begin n_bad++; $display("FAIL ones_ofifo_rise: got %b, want 1", v_rec); end
      n_cmp++;
      if (v_mid !== 1'b1) begin n_bad++; $display("FAIL ones_ofifo_hold: got %b, want 1", v_mid); end
      n_cmp++;
      if (v_end !== 1'b0) begin n_bad++; $display("FAIL ones_ofifo_fall: got %b, want 0", v_end); end
      for (int a = 7; a >= 0; a--) begin
         read_pmem(a, 1'b1);
         n_cmp++;
         if (sfp_out !== {8{16'd9}}) begin
            n_bad++;
            $display("FAIL ones_addr%0d: got %h, want %h", a, sfp_out, {8{16'd9}});
         end
      end
   endtask

   task automatic test_neg();
      logic v_rec, v_mid, v_end;
      do_reset();
      for (int k = 0; k < 9; k++) begin
         act_w[k] = 32'h2222_2222;
         wt_w[k]  = 32'hDDDD_DDDD;
      end
      for (int ic = 0; ic < 8; ic++) run_pass(ic, 1'b0);
      drain(v_rec, v_mid, v_end);
      for (int a = 0; a < 8; a++) begin
         read_pmem(a, 1'b1);
         n_cmp++;
         if (sfp_out !== {8{16'hFE50}}) begin
            n_bad++;
            $display("FAIL neg_pass_addr%0d: got %h, want %h", a, sfp_out, {8{16'hFE50}});
         end
         read_pmem(a, 1'b0);
         n_cmp++;
         if (sfp_out !== 128'h0) begin
            n_bad++;
            $display("FAIL neg_relu_addr%0d: got %h, want 0", a, sfp_out);
         end
      end
   endtask

   task automatic test_wptr_overflow();
      logic v_rec, v_mid, v_end;
      do_reset();
      for (int k = 0; k < 10; k++) begin
         act_w[k] = $urandom();
         wt_w[k]  = $urandom();
         write_xmem(k, act_w[k]);
         write_xmem(xmem_wt_base + k, wt_w[k]);
      end
      stage(0, xmem_wt_base, 10);
      pop(9, 1'b1);
      settle();
      model_pass();
      for (int k = 0; k < 9; k++) begin
         act_w[k] = $urandom();
         wt_w[k]  = $urandom();
      end
      run_pass(2, 1'b0);
      drain(v_rec, v_mid, v_end);
      for (int a = 0; a < 8; a++) begin
         read_pmem(a, 1'b1);
         n_cmp++;
         if (sfp_out !== pmem_m[a]) begin
            n_bad++;
            $display("FAIL wptr_addr%0d: got %h, want %h", a, sfp_out, pmem_m[a]);
         end
      end
   endtask

   task automatic test_random();
      logic v_rec, v_mid, v_end;
      do_reset();
      for (int p = 0; p < 3; p++) begin
         for (int k = 0; k < 9; k++) begin
            act_w[k] = $urandom();
            wt_w[k]  = $urandom();
         end
         run_pass(p, p == 1);
      end
      drain(v_rec, v_mid, v_end);
      for (int a = 0; a < 8; a++) begin
         read_pmem(a, 1'b1);
         n_cmp++;
         if (sfp_out !== pmem_m[a]) begin
            n_bad++;
            $display("FAIL rand_pass_addr%0d: got %h, want %h", a, sfp_out, pmem_m[a]);
         end
         read_pmem(a, 1'b0);
         n_cmp++;
         if (sfp_out !== relu_row(pmem_m[a])) begin
            n_bad++;
            $display("FAIL rand_relu_addr%0d: got %h, want %h", a, sfp_out, relu_row(pmem_m[a]));
         end
      end
   endtask

   task automatic test_reset_mid();
      logic v_rec, v_mid, v_end;
      do_reset();
      for (int k = 0; k < 9; k++) begin
         act_w[k] = $urandom();
         wt_w[k]  = $urandom();
         write_xmem(k, act_w[k]);
         write_xmem(xmem_wt_base + k, wt_w[k]);
      end
      stage(0, xmem_wt_base, 9);
      pop(4, 1'b1);
      inst = idle();
      inst[inst_recall] = 1'b1;
      cyc();
      inst = idle();
      reset = 1'b1;
      #2;
      n_cmp++;
      if (ofifo_valid !== 1'b0) begin n_bad++; $display("FAIL midreset_ofifo: got %b, want 0", ofifo_valid); end
      n_cmp++;
      if (sfp_out !== 128'h0) begin n_bad++; $display("FAIL midreset_sfp: got %h, want 0", sfp_out); end
      cyc();
      reset = 1'b0;
      cyc();
      for (int r = 0; r < 8; r++)
         for (int c = 0; c < 8; c++) acc_m[r][c] = '0;
      for (int k = 0; k < 9; k++) begin
         act_w[k] = 32'h1111_1111;
         wt_w[k]  = 32'h1111_1111;
      end
      run_pass(0, 1'b0);
      drain(v_rec, v_mid, v_end);
      for (int a = 0; a < 8; a++) begin
         read_pmem(a, 1'b1);
         n_cmp++;
         if (sfp_out !== {8{16'd9}}) begin
            n_bad++;
            $display("FAIL midreset_addr%0d: got %h, want %h", a, sfp_out, {8{16'd9}});
         end
      end
   endtask

   task automatic test_rw_collision();
      logic [127:0] old_row;
      run_pass(0, 1'b0);
      old_row = pmem_m[7];
      inst = idle();
      inst[inst_recall] = 1'b1;
      cyc();
      inst = idle();
      inst[inst_a_pmem +: addr_bw] = addr_bw'(7);
      cyc();
      inst = idle();
      inst[inst_cen_pmem]  = 1'b0;
      inst[inst_wen_pmem]  = 1'b1;
      inst[inst_pass_psum] = 1'b1;
      inst[inst_a_pmem +: addr_bw] = addr_bw'(7);
      cyc();
      pmem_m[7] = model_row(7);
      n_cmp++;
      if (sfp_out !== old_row) begin
         n_bad++;
         $display("FAIL collide_old: got %h, want %h", sfp_out, old_row);
      end
      n_cmp++;
      if (ofifo_valid !== 1'b1) begin n_bad++; $display("FAIL collide_ofifo: got %b, want 1", ofifo_valid); end
      read_pmem(7, 1'b1);
      n_cmp++;
      if (sfp_out !== {8{16'd18}}) begin
         n_bad++;
         $display("FAIL collide_new: got %h, want %h", sfp_out, {8{16'd18}});
      end
      inst = idle();
   endtask

   initial begin
      reset  = 1'b1;
      inst   = idle();
      D_xmem = '0;
      test_reset();
      test_ones();
      test_neg();
      test_wptr_overflow();
      test_random();
      test_reset_mid();
      test_rw_collision();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
